// File: rtl/unpacker_gen_if.sv
// Handshake bundle for the width-reduction unpacker: the wide input transfer,
// the narrow output beat and the status strobes.
interface unpacker_gen_if #(
    parameter int IN_BYTES  = 160,
    parameter int OUT_BYTES = 32,
    parameter int VBC_W     = $clog2(IN_BYTES + 1)
);
    logic                   val;
    logic                   sop;
    logic                   eop;
    logic [VBC_W-1:0]       vbc;
    logic [IN_BYTES*8-1:0]  data;
    logic                   ready;

    logic                   o_val;
    logic                   o_sop;
    logic                   o_eop;
    logic [VBC_W-1:0]       o_vbc;
    logic [OUT_BYTES*8-1:0] o_data;
    logic                   o_ready;

    logic                   idle;
    logic                   vbc_err;

    modport master (
        output val, sop, eop, vbc, data, o_ready,
        input  ready, o_val, o_sop, o_eop, o_vbc, o_data, idle, vbc_err
    );

    modport slave (
        input  val, sop, eop, vbc, data, o_ready,
        output ready, o_val, o_sop, o_eop, o_vbc, o_data, idle, vbc_err
    );
endinterface

// File: rtl/unpacker_gen.sv
// Width-reduction unpacker: holds one wide transfer and replays it as a train of
// OUT_BYTES beats with sop/eop/vbc marking, accepting the next transfer on the last beat.
module unpacker_gen #(
    parameter int IN_BYTES  = 160,
    parameter int OUT_BYTES = 32,
    parameter int VBC_W     = $clog2(IN_BYTES + 1)
) (
    input  logic          clk,
    input  logic          reset_L,
    unpacker_gen_if.slave bus
);
    localparam int NBEATS = IN_BYTES / OUT_BYTES;
    localparam int OW     = OUT_BYTES * 8;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t                state_r;
    logic                  sop_r;
    logic                  eop_r;
    logic                  vbc_err_r;
    logic [IN_BYTES*8-1:0] data_r;
    logic [VBC_W-1:0]      last_vbc_r;
    logic [VBC_W-1:0]      total_r;
    logic [VBC_W-1:0]      beat_r;

    logic [VBC_W-1:0]      vbc_m1_s;
    logic [VBC_W-1:0]      tot_s;
    logic [VBC_W-1:0]      last_vbc_s;
    logic                  legal_s;
    logic                  send_s;
    logic                  last_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  load_s;
    logic [VBC_W-1:0]      cur_vbc_s;
    logic [OW-1:0]         slice_s;
    logic [OW-1:0]         beat_data_s;

    // Decode the incoming transfer; working from vbc-1 keeps the beat count and
    // last-beat size inside VBC_W bits even for vbc == IN_BYTES.
    always_comb begin
        vbc_m1_s   = bus.vbc - VBC_W'(1);
        legal_s    = (bus.vbc != VBC_W'(0)) && (bus.vbc <= VBC_W'(IN_BYTES));
        tot_s      = (vbc_m1_s / VBC_W'(OUT_BYTES)) + VBC_W'(1);
        last_vbc_s = (vbc_m1_s % VBC_W'(OUT_BYTES)) + VBC_W'(1);
    end

    // Select and mask the current beat, and derive the input handshake.
    always_comb begin
        send_s    = (state_r == ST_SEND);
        last_s    = (beat_r == (total_r - VBC_W'(1)));
        cur_vbc_s = last_s ? last_vbc_r : VBC_W'(OUT_BYTES);
        slice_s   = '0;
        for (int k = 0; k < NBEATS; k++) begin
            slice_s = (beat_r == VBC_W'(k)) ? data_r[OW*k +: OW] : slice_s;
        end
        beat_data_s = '0;
        for (int j = 0; j < OUT_BYTES; j++) begin
            beat_data_s[8*j +: 8] = (VBC_W'(j) < cur_vbc_s) ? slice_s[8*j +: 8] : 8'h00;
        end
        ready_s  = (state_r == ST_IDLE) || (send_s && bus.o_ready && last_s);
        accept_s = bus.val && ready_s;
        load_s   = accept_s && legal_s;
    end

    assign bus.ready   = ready_s;
    assign bus.o_val   = send_s;
    assign bus.o_sop   = send_s && sop_r && (beat_r == VBC_W'(0));
    assign bus.o_eop   = send_s && eop_r && last_s;
    assign bus.o_vbc   = send_s ? cur_vbc_s : VBC_W'(0);
    assign bus.o_data  = send_s ? beat_data_s : OW'(0);
    assign bus.idle    = (state_r == ST_IDLE);
    assign bus.vbc_err = vbc_err_r;

    // Control FSM together with the holding register and beat counter.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r    <= ST_RESET;
            sop_r      <= 1'b0;
            eop_r      <= 1'b0;
            vbc_err_r  <= 1'b0;
            data_r     <= '0;
            last_vbc_r <= '0;
            total_r    <= '0;
            beat_r     <= '0;
        end else begin
            vbc_err_r <= accept_s && !legal_s;
            if (load_s) begin
                sop_r      <= bus.sop;
                eop_r      <= bus.eop;
                data_r     <= bus.data;
                last_vbc_r <= last_vbc_s;
                total_r    <= tot_s;
                beat_r     <= VBC_W'(0);
            end else if (send_s && bus.o_ready && !last_s) begin
                beat_r <= beat_r + VBC_W'(1);
            end else begin
                beat_r <= beat_r;
            end
            case (state_r)
                ST_RESET: state_r <= ST_IDLE;
                ST_IDLE:  state_r <= load_s ? ST_SEND : ST_IDLE;
                ST_SEND: begin
                    if (bus.o_ready && last_s) begin
                        state_r <= load_s ? ST_SEND : ST_IDLE;
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                default:  state_r <= ST_RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_unpacker_gen.sv
// Bench for unpacker_gen: a queue-of-beats reference model checked against the
// design on every falling edge, driven by directed scenarios and random traffic.
module tb_unpacker_gen;
    localparam int IB = 160;
    localparam int OB = 32;
    localparam int VW = $clog2(IB + 1);
    localparam int DW = IB * 8;
    localparam int OW = OB * 8;

    logic clk     = 1'b0;
    logic reset_L = 1'b0;

    always #5 clk = ~clk;

    unpacker_gen_if #(.IN_BYTES(IB), .OUT_BYTES(OB), .VBC_W(VW)) bus ();

    unpacker_gen #(.IN_BYTES(IB), .OUT_BYTES(OB), .VBC_W(VW)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    typedef struct {
        logic          sop;
        logic          eop;
        int            vbc;
        logic [OW-1:0] data;
    } beat_t;

    beat_t q[$];
    bit    rst_flag   = 1'b1;
    bit    err_exp    = 1'b0;
    bit    m_acc;
    bit    c_live;
    beat_t c_h;
    int    vectors    = 0;
    int    fails      = 0;
    int    beats_seen = 0;
    int    errs_seen  = 0;

    function automatic int n_beats(int vb);
        return (vb + OB - 1) / OB;
    endfunction

    function automatic int beat_vbc(int vb, int k);
        return (vb - OB * k > OB) ? OB : (vb - OB * k);
    endfunction

    function automatic bit legal(int vb);
        return (vb >= 1) && (vb <= IB);
    endfunction

    function automatic bit model_ready();
        if (!reset_L || rst_flag) return 1'b0;
        return (q.size() == 0) || (q.size() == 1 && bus.o_ready);
    endfunction

    task automatic push_transfer(logic s, logic e, int vb, logic [DW-1:0] d);
        beat_t b;
        for (int k = 0; k < n_beats(vb); k++) begin
            b.sop  = s && (k == 0);
            b.eop  = e && (k == n_beats(vb) - 1);
            b.vbc  = beat_vbc(vb, k);
            b.data = '0;
            for (int j = 0; j < b.vbc; j++) b.data[8*j +: 8] = d[8*(OB*k + j) +: 8];
            q.push_back(b);
        end
    endtask

    task automatic chk(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model advances on each rising edge from the bench's own view of the handshakes.
    always @(posedge clk) begin
        if (!reset_L) begin
            q.delete();
            rst_flag = 1'b1;
            err_exp  = 1'b0;
        end else if (rst_flag) begin
            rst_flag = 1'b0;
            err_exp  = 1'b0;
        end else begin
            m_acc = bus.val && model_ready();
            if (q.size() > 0 && bus.o_ready) void'(q.pop_front());
            if (m_acc && legal(int'(bus.vbc))) push_transfer(bus.sop, bus.eop, int'(bus.vbc), bus.data);
            err_exp = m_acc && !legal(int'(bus.vbc));
        end
    end

    // Compare every output against the model midway through each cycle.
    always @(negedge clk) begin
        c_live = reset_L && !rst_flag;
        vectors++;
        if (c_live && q.size() > 0) begin
            c_h = q[0];
        end else begin
            c_h.sop  = 1'b0;
            c_h.eop  = 1'b0;
            c_h.vbc  = 0;
            c_h.data = '0;
        end
        chk("o_val",   OW'(bus.o_val),   OW'(c_live && q.size() > 0));
        chk("o_sop",   OW'(bus.o_sop),   OW'(c_h.sop));
        chk("o_eop",   OW'(bus.o_eop),   OW'(c_h.eop));
        chk("o_vbc",   OW'(bus.o_vbc),   OW'(c_h.vbc));
        chk("o_data",  bus.o_data,       c_h.data);
        chk("ready",   OW'(bus.ready),   OW'(model_ready()));
        chk("idle",    OW'(bus.idle),    OW'(c_live && q.size() == 0));
        chk("vbc_err", OW'(bus.vbc_err), OW'(c_live && err_exp));
        if (bus.o_val && bus.o_ready) beats_seen++;
        if (bus.vbc_err) errs_seen++;
    end

    task automatic cyc(logic rl, logic v, logic s, logic e, int vb, logic ordy);
        reset_L     = rl;
        bus.val     = v;
        bus.sop     = s;
        bus.eop     = e;
        bus.vbc     = VW'(vb);
        bus.o_ready = ordy;
        for (int w = 0; w < IB / 4; w++) bus.data[32*w +: 32] = $urandom;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.val = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
        bus.vbc = '0; bus.data = '0; bus.o_ready = 1'b0;

        chk("pin_nbeats_70",  OW'(n_beats(70)),      OW'(3));
        chk("pin_lastvbc_70", OW'(beat_vbc(70, 2)),  OW'(6));
        chk("pin_nbeats_160", OW'(n_beats(160)),     OW'(5));
        chk("pin_lastvbc_160",OW'(beat_vbc(160, 4)), OW'(32));
        chk("pin_nbeats_33",  OW'(n_beats(33)),      OW'(2));
        chk("pin_lastvbc_33", OW'(beat_vbc(33, 1)),  OW'(1));
        chk("pin_nbeats_20",  OW'(n_beats(20)),      OW'(1));

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);

        // Full-width transfer right after reset release.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 160, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 160, 1'b1);
        beats_seen = 0;
        repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        chk("beats_full", OW'(beats_seen), OW'(5));

        // Partial last beat.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 70, 1'b1);
        beats_seen = 0;
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        chk("beats_70", OW'(beats_seen), OW'(3));

        // Back-to-back 64 then 20.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 64, 1'b1);
        beats_seen = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 20, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 20, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        chk("beats_b2b", OW'(beats_seen), OW'(3));

        // Backpressure during a full transfer.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 160, 1'b1);
        beats_seen = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        chk("beats_bp", OW'(beats_seen), OW'(5));

        // Illegal byte counts.
        errs_seen = 0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 200, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        chk("err_pulses", OW'(errs_seen), OW'(2));

        // Asynchronous reset during beat 2.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 160, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        #2 reset_L = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        beats_seen = 0;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        chk("beats_after_rst", OW'(beats_seen), OW'(0));

        // Random traffic with occasional illegal counts and resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int vb;
            r  = int'($urandom_range(0, 99));
            vb = (r < 8) ? ((r < 4) ? 0 : int'($urandom_range(IB + 1, 255)))
                         : int'($urandom_range(1, IB));
            cyc($urandom_range(0, 499) != 0, $urandom_range(0, 99) < 60,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), vb,
                $urandom_range(0, 99) < 75);
        end
        repeat (8) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
